// File: rtl/platform_pll_pkg.sv
// ---------------------------------------------------------------------------
// platform_pll_pkg
//
// Shared definitions for the PLL reset sequencer: the sequencer state
// encoding, the default timing constants and a couple of small helpers
// used to size the shared cycle counter.
// ---------------------------------------------------------------------------
package platform_pll_pkg;

    // Sequencer states, in the order the nominal bring-up walks through them.
    typedef enum logic [2:0] {
        PLLRST    = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_state_t;

    // Default timing, expressed in refclk (50 MHz) cycles.
    localparam int DEF_PLL_RST_CYCLES = 16;
    localparam int DEF_LOCK_TIMEOUT   = 65536;
    localparam int DEF_STABLE_CYCLES  = 1024;
    localparam int DEF_MAX_RETRIES    = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // A counter that must reach (m - 1) needs clog2(m) bits; never fewer
    // than one so a degenerate parameter set still elaborates.
    function automatic int cnt_width(input int m);
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/platform_pll_reset_ctrl_sync2.sv
// ---------------------------------------------------------------------------
// platform_sync2
//
// Plain two-flop synchronizer for bringing an asynchronous level into the
// clk domain. Generic width so it can be reused for other slow async
// status inputs (each bit is synchronized independently).
//
// Ports:
//   clk  in          destination clock
//   rst  in          synchronous active-high reset, clears both stages
//   d    in  [W-1:0] asynchronous input
//   q    out [W-1:0] synchronized output, two clk cycles of latency
// ---------------------------------------------------------------------------
module platform_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First stage may go metastable; the second stage gives it a full
    // cycle to resolve before anything downstream looks at it.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/platform_pll_reset_ctrl.sv
// ---------------------------------------------------------------------------
// platform_pll_reset_ctrl
//
// Sequences PLL bring-up from the reference clock: pulses the PLL reset,
// waits for lock (with bounded retries), requires lock to be stable for a
// while, then releases the system reset. Lock loss while running restarts
// the whole sequence and is counted.
//
// Ports:
//   refclk      in      reference clock, all logic on its rising edge
//   rst         in      synchronous active-high reset
//   locked      in      PLL lock, asynchronous to refclk
//   relock_req  in      one-cycle request to restart from RUN or FAULT
//   pll_rst     out     reset to the PLL (registered)
//   sys_rst     out     system reset, low only while running (registered)
//   ready       out     high only in RUN (registered)
//   fault       out     high only in FAULT (registered)
//   retry_cnt   out [2] lock timeouts since the last RUN entry
//   loss_cnt    out [8] lock losses seen in RUN, saturating at 255
// ---------------------------------------------------------------------------
module platform_pll_reset_ctrl
    import platform_pll_pkg::*;
#(
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    localparam int CNT_W = cnt_width(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));

    localparam logic [CNT_W-1:0] PLL_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [1:0]       RETRY_LIMIT = 2'(MAX_RETRIES);

    pll_state_t       state;
    pll_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [1:0]       retry_next;
    logic [1:0]       retry_inc;
    logic [7:0]       loss_next;
    logic             lk;

    platform_sync2 #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (locked),
        .q   (lk)
    );

    // Next-state logic. Every decision uses the synchronized lock. In RUN a
    // lock loss wins over a simultaneous relock request so the loss is
    // still counted.
    always_comb begin
        state_next = state;
        retry_next = retry_cnt;
        loss_next  = loss_cnt;
        retry_inc  = retry_cnt + 2'd1;
        case (state)
            PLLRST: begin
                if (cnt == PLL_LAST) begin
                    state_next = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (lk) begin
                    state_next = STABLE;
                end else if (cnt == LOCK_LAST) begin
                    retry_next = retry_inc;
                    state_next = (retry_inc == RETRY_LIMIT) ? FAULT : PLLRST;
                end
            end
            STABLE: begin
                if (!lk) begin
                    state_next = WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!lk) begin
                    state_next = PLLRST;
                    loss_next  = (loss_cnt == 8'hFF) ? loss_cnt : loss_cnt + 8'd1;
                end else if (relock_req) begin
                    state_next = PLLRST;
                    retry_next = 2'd0;
                end
            end
            FAULT: begin
                if (relock_req) begin
                    state_next = PLLRST;
                    retry_next = 2'd0;
                end
            end
            default: begin
                state_next = PLLRST;
            end
        endcase

        if (state_next == RUN && state != RUN) begin
            retry_next = 2'd0;
        end
    end

    // The one shared counter restarts on every state change and only runs
    // in the timed states, so it never wraps while parked in RUN or FAULT.
    always_comb begin
        cnt_next = cnt;
        if (state_next != state) begin
            cnt_next = '0;
        end else if (state == PLLRST || state == WAIT_LOCK || state == STABLE) begin
            cnt_next = cnt + 1'b1;
        end
    end

    // State and outputs register together. Outputs are decoded from the
    // next state so they change on the same edge as the state does.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state     <= PLLRST;
            cnt       <= '0;
            retry_cnt <= 2'd0;
            loss_cnt  <= 8'd0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            fault     <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            retry_cnt <= retry_next;
            loss_cnt  <= loss_next;
            pll_rst   <= (state_next == PLLRST) || (state_next == FAULT);
            sys_rst   <= (state_next != RUN);
            ready     <= (state_next == RUN);
            fault     <= (state_next == FAULT);
        end
    end

endmodule

// File: tb/tb_platform_pll_reset_ctrl.sv
// ---------------------------------------------------------------------------
// tb_platform_pll_reset_ctrl
//
// Scenario bench for the PLL reset sequencer. Expected timing comes from
// arithmetic on the sequencer's timing parameters; expected loss counts
// from a saturating counter kept here.
// ---------------------------------------------------------------------------
module tb_platform_pll_reset_ctrl;

    localparam int P = 4;
    localparam int L = 32;
    localparam int S = 8;
    localparam int R = 2;

    // Inputs are driven 1 time unit after an edge, so they are first
    // sampled on the following edge; two synchronizer stages then precede
    // the FSM decision, and S stable cycles precede release.
    localparam int RELEASE_TICKS   = 1 + 2 + S;
    localparam int LOCKED_RELEASE  = 1 + S;
    localparam int LOSS_TICKS      = 3;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fault;
    logic [1:0] retry_cnt;
    logic [7:0] loss_cnt;

    int checks = 0;
    int passes = 0;
    int loss_model = 0;
    bit mon_en = 1'b0;

    platform_pll_reset_ctrl #(
        .PLL_RST_CYCLES (P),
        .LOCK_TIMEOUT   (L),
        .STABLE_CYCLES  (S),
        .MAX_RETRIES    (R)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .locked     (locked),
        .relock_req (relock_req),
        .pll_rst    (pll_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .fault      (fault),
        .retry_cnt  (retry_cnt),
        .loss_cnt   (loss_cnt)
    );

    always #5 refclk = ~refclk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "[TB] watchdog");
    end

    // System reset may only be low while running, and ready/fault are
    // mutually exclusive.
    always @(negedge refclk) begin
        if (mon_en) begin
            checks++;
            if (((sys_rst === 1'b0) !== (ready === 1'b1)) || (ready === 1'b1 && fault === 1'b1)) begin
                $display("[TB] FAIL invariant: sys_rst=%b ready=%b fault=%b, required sys_rst low only with ready, never ready with fault",
                         sys_rst, ready, fault);
            end else begin
                passes++;
            end
        end
    end

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    function automatic int loss_step(input int cur);
        return (cur < 255) ? cur + 1 : 255;
    endfunction

    task automatic do_reset(input logic lock_in);
        rst = 1'b1;
        locked = lock_in;
        relock_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        loss_model = 0;
    endtask

    // Counts samples with pll_rst high, starting at the first one seen.
    task automatic pll_pulse_len(output int n);
        int k = 0;
        n = 0;
        while (pll_rst !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        while (pll_rst === 1'b1 && n < 200) begin
            n++;
            tick();
        end
    endtask

    task automatic release_after(input int d, output int e);
        repeat (d) tick();
        locked = 1'b1;
        e = 0;
        while (ready !== 1'b1 && e < 200) begin
            tick();
            e++;
        end
    endtask

    task automatic test_reset();
        logic [13:0] got;
        logic [13:0] exp;
        rst = 1'b1;
        locked = 1'b0;
        relock_req = 1'b0;
        repeat (3) tick();
        mon_en = 1'b1;
        exp = {1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0};
        got = {pll_rst, sys_rst, ready, fault, retry_cnt, loss_cnt};
        checks++;
        if (got !== exp) $display("[TB] FAIL reset_values: got %h, required %h", got, exp);
        else passes++;
    endtask

    task automatic test_nominal();
        int n;
        int e;
        rst = 1'b0;
        loss_model = 0;
        pll_pulse_len(n);
        checks++;
        if (n !== P) $display("[TB] FAIL nominal_pll_rst_width: got %0d cycles, required %0d", n, P);
        else passes++;
        release_after(10, e);
        checks++;
        if (e !== RELEASE_TICKS) $display("[TB] FAIL nominal_release: got %0d ticks, required %0d", e, RELEASE_TICKS);
        else passes++;
        checks++;
        if ({sys_rst, retry_cnt, loss_cnt} !== {1'b0, 2'd0, 8'd0})
            $display("[TB] FAIL nominal_run_outputs: got sys_rst=%b retry=%0d loss=%0d, required 0/0/0", sys_rst, retry_cnt, loss_cnt);
        else passes++;
    endtask

    task automatic test_glitch();
        int n;
        int e;
        int d;
        int h;
        do_reset(1'b0);
        pll_pulse_len(n);
        d = $urandom_range(0, 15);
        h = $urandom_range(1, 6);
        repeat (d) tick();
        locked = 1'b1;
        repeat (h) tick();
        locked = 1'b0;
        tick();
        locked = 1'b1;
        e = 0;
        while (ready !== 1'b1 && e < 200) begin
            tick();
            e++;
        end
        checks++;
        if (e !== RELEASE_TICKS) $display("[TB] FAIL glitch_release (high %0d): got %0d ticks, required %0d", h, e, RELEASE_TICKS);
        else passes++;
        checks++;
        if (retry_cnt !== 2'd0) $display("[TB] FAIL glitch_retry: got %0d, required 0", retry_cnt);
        else passes++;
    endtask

    task automatic test_loss_in_run();
        int k = 0;
        int n;
        int e;
        locked = 1'b0;
        while (sys_rst !== 1'b1 && k < 20) begin
            tick();
            k++;
        end
        loss_model = loss_step(loss_model);
        checks++;
        if (k !== LOSS_TICKS) $display("[TB] FAIL loss_latency: got %0d ticks, required %0d", k, LOSS_TICKS);
        else passes++;
        checks++;
        if ({pll_rst, ready, loss_cnt} !== {1'b1, 1'b0, 8'(loss_model)})
            $display("[TB] FAIL loss_outputs: got pll_rst=%b ready=%b loss=%0d, required 1/0/%0d", pll_rst, ready, loss_cnt, loss_model);
        else passes++;
        pll_pulse_len(n);
        checks++;
        if (n !== P) $display("[TB] FAIL loss_pll_rst_width: got %0d, required %0d", n, P);
        else passes++;
        release_after($urandom_range(0, 20), e);
        checks++;
        if (e !== RELEASE_TICKS) $display("[TB] FAIL loss_rerelease: got %0d ticks, required %0d", e, RELEASE_TICKS);
        else passes++;
    endtask

    task automatic test_relock_in_run();
        int n;
        int e = 0;
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        checks++;
        if ({pll_rst, sys_rst, loss_cnt, retry_cnt} !== {1'b1, 1'b1, 8'(loss_model), 2'd0})
            $display("[TB] FAIL relock_run: got pll_rst=%b sys_rst=%b loss=%0d retry=%0d, required 1/1/%0d/0",
                     pll_rst, sys_rst, loss_cnt, retry_cnt, loss_model);
        else passes++;
        pll_pulse_len(n);
        checks++;
        if (n !== P) $display("[TB] FAIL relock_pll_rst_width: got %0d, required %0d", n, P);
        else passes++;
        while (ready !== 1'b1 && e < 200) begin
            tick();
            e++;
        end
        checks++;
        if (e !== LOCKED_RELEASE) $display("[TB] FAIL relock_release: got %0d ticks, required %0d", e, LOCKED_RELEASE);
        else passes++;
    endtask

    task automatic test_simultaneous();
        int k = 0;
        locked = 1'b0;
        tick();
        tick();
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        loss_model = loss_step(loss_model);
        checks++;
        if ({sys_rst, loss_cnt} !== {1'b1, 8'(loss_model)})
            $display("[TB] FAIL simultaneous_loss: got sys_rst=%b loss=%0d, required 1/%0d", sys_rst, loss_cnt, loss_model);
        else passes++;
        locked = 1'b1;
        while (ready !== 1'b1 && k < 200) begin
            tick();
            k++;
        end
        checks++;
        if (ready !== 1'b1) $display("[TB] FAIL simultaneous_recover: got ready=%b, required 1", ready);
        else passes++;
    endtask

    task automatic test_reset_mid_stable();
        logic [13:0] got;
        logic [13:0] exp;
        int n;
        int e = 0;
        locked = 1'b0;
        repeat (LOSS_TICKS) tick();
        loss_model = loss_step(loss_model);
        pll_pulse_len(n);
        locked = 1'b1;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        exp = {1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0};
        got = {pll_rst, sys_rst, ready, fault, retry_cnt, loss_cnt};
        checks++;
        if (got !== exp) $display("[TB] FAIL mid_stable_reset (loss before %0d): got %h, required %h", loss_model, got, exp);
        else passes++;
        loss_model = 0;
        rst = 1'b0;
        pll_pulse_len(n);
        checks++;
        if (n !== P) $display("[TB] FAIL mid_stable_restart_width: got %0d, required %0d", n, P);
        else passes++;
        while (ready !== 1'b1 && e < 200) begin
            tick();
            e++;
        end
        checks++;
        if (e !== LOCKED_RELEASE) $display("[TB] FAIL mid_stable_release: got %0d ticks, required %0d", e, LOCKED_RELEASE);
        else passes++;
    endtask

    // Lock never arrives: two full reset+timeout rounds, then FAULT.
    task automatic test_timeout();
        logic [4:0] got;
        logic [4:0] exp;
        logic       e_pll;
        logic       e_fault;
        logic [1:0] e_retry;
        do_reset(1'b0);
        for (int t = 0; t <= 2 * P + 2 * L + 3; t++) begin
            e_fault = (t >= 2 * P + 2 * L);
            e_pll   = (t < P) || (t >= P + L && t < 2 * P + L) || e_fault;
            e_retry = (t < P + L) ? 2'd0 : (t < 2 * P + 2 * L) ? 2'd1 : 2'(R);
            exp = {e_pll, 1'b1, e_fault, e_retry};
            got = {pll_rst, sys_rst, fault, retry_cnt};
            checks++;
            if (got !== exp) $display("[TB] FAIL timeout_seq t=%0d: got %b, required %b", t, got, exp);
            else passes++;
            relock_req = (t == 50);
            tick();
        end
        relock_req = 1'b0;
        checks++;
        if ({fault, retry_cnt} !== {1'b1, 2'(R)})
            $display("[TB] FAIL timeout_fault_sticky: got fault=%b retry=%0d, required 1/%0d", fault, retry_cnt, R);
        else passes++;
    endtask

    task automatic test_recovery();
        int n;
        int e;
        relock_req = 1'b1;
        tick();
        relock_req = 1'b0;
        checks++;
        if ({fault, retry_cnt, pll_rst, sys_rst} !== {1'b0, 2'd0, 1'b1, 1'b1})
            $display("[TB] FAIL recovery_outputs: got fault=%b retry=%0d pll_rst=%b sys_rst=%b, required 0/0/1/1",
                     fault, retry_cnt, pll_rst, sys_rst);
        else passes++;
        pll_pulse_len(n);
        checks++;
        if (n !== P) $display("[TB] FAIL recovery_pll_rst_width: got %0d, required %0d", n, P);
        else passes++;
        release_after($urandom_range(0, 20), e);
        checks++;
        if (e !== RELEASE_TICKS) $display("[TB] FAIL recovery_release: got %0d ticks, required %0d", e, RELEASE_TICKS);
        else passes++;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 257; i++) begin
            int k = 0;
            locked = 1'b0;
            while (sys_rst !== 1'b1 && k < 20) begin
                tick();
                k++;
            end
            locked = 1'b1;
            loss_model = loss_step(loss_model);
            checks++;
            if (loss_cnt !== 8'(loss_model)) $display("[TB] FAIL saturation_loss i=%0d: got %0d, required %0d", i, loss_cnt, loss_model);
            else passes++;
            k = 0;
            while (ready !== 1'b1 && k < 100) begin
                tick();
                k++;
            end
            checks++;
            if (ready !== 1'b1) $display("[TB] FAIL saturation_rerun i=%0d: got ready=%b, required 1", i, ready);
            else passes++;
        end
        checks++;
        if (loss_cnt !== 8'd255) $display("[TB] FAIL loss_saturated: got %0d, required 255", loss_cnt);
        else passes++;
    endtask

    initial begin
        $display("[TB] platform_pll_reset_ctrl bench start");
        test_reset();
        test_nominal();
        test_glitch();
        test_loss_in_run();
        test_relock_in_run();
        test_simultaneous();
        test_reset_mid_stable();
        test_timeout();
        test_recovery();
        test_saturation();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/platform_pll_reset_ctrl.md
PLATFORM_PLL_RESET_CTRL -- requirements
Module: platform_pll_reset_ctrl

Interface
REQ-001 Parameter PLL_RST_CYCLES, default 16: cycles `pll_rst` is held high per PLL reset pulse.
REQ-002 Parameter LOCK_TIMEOUT, default 65536: cycles allowed in WAIT_LOCK before a retry.
REQ-003 Parameter STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required before release.
REQ-004 Parameter MAX_RETRIES, default 3: timeouts allowed before FAULT.
REQ-005 refclk  in  1  sole clock, 50 MHz reference domain; all logic on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 locked  in  1  PLL lock indication, asynchronous to refclk.
REQ-008 relock_req  in  1  single-cycle pulse requesting a full PLL re-lock.
REQ-009 pll_rst  out  1  reset to the PLL, registered.
REQ-010 sys_rst  out  1  system reset for outclk consumers, active-high, registered.
REQ-011 ready  out  1  high only in RUN, registered.
REQ-012 fault  out  1  high only in FAULT, registered.
REQ-013 retry_cnt  out  2  timeouts since the last RUN entry.
REQ-014 loss_cnt  out  8  lock losses seen in RUN, saturating at 255.

Function
REQ-015 `locked` SHALL pass through a 2-flop synchronizer; all decisions SHALL use the synchronized value `lk`.
REQ-016 States: PLLRST, WAIT_LOCK, STABLE, RUN, FAULT, with one shared cycle counter cleared on every state change.
REQ-017 PLLRST: pll_rst=1 and sys_rst=1; after exactly PLL_RST_CYCLES cycles go to WAIT_LOCK.
REQ-018 WAIT_LOCK: pll_rst=0 and sys_rst=1; lk=1 goes to STABLE.
REQ-019 WAIT_LOCK timeout: if LOCK_TIMEOUT cycles elapse with lk=0, retry_cnt increments; if the new value equals MAX_RETRIES go to FAULT, otherwise go to PLLRST.
REQ-020 STABLE: lk=0 returns to WAIT_LOCK with the counter cleared and retry_cnt unchanged; STABLE_CYCLES consecutive lk=1 cycles go to RUN.
REQ-021 Latency: sys_rst SHALL fall on rising edge (locked-sampled-high edge + 2 + STABLE_CYCLES) in the nominal case, in the same cycle ready rises.
REQ-022 Entering RUN clears retry_cnt.
REQ-023 RUN: lk=0 goes to PLLRST, increments loss_cnt (saturating), and asserts sys_rst on the next edge.
REQ-024 relock_req in RUN or FAULT goes to PLLRST and clears retry_cnt; in other states it is ignored.
REQ-025 Simultaneous lk=0 and relock_req in RUN: treated as lock loss, so loss_cnt increments.
REQ-026 FAULT: pll_rst=1 and sys_rst=1, sticky until relock_req or rst.
REQ-027 sys_rst SHALL never be low unless state is RUN.

Reset
REQ-028 Reset values: state=PLLRST, counter=0, synchronizer=0, pll_rst=1, sys_rst=1, ready=0, fault=0, retry_cnt=0, loss_cnt=0.
REQ-029 rst asserted mid-operation, in any state, SHALL restore the values above on the next edge, and the PLLRST sequence SHALL restart from count 0.

Structure
REQ-030 The state enum and default timing constants SHALL live in shared package platform_pll_pkg.
REQ-031 The counter SHALL be sized as clog2 of the maximum of the three cycle parameters.
REQ-032 The synchronizer SHALL be a sub-module, platform_sync2, reusable for other asynchronous inputs.

Verification
Parameters for every scenario: PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2.
REQ-033 Nominal: release rst, locked rises 10 cycles after pll_rst falls -> pll_rst high exactly 4 cycles; sys_rst falls and ready rises 10 edges after locked is first sampled high.
REQ-034 Glitch: locked high 5 cycles, low 1 cycle, then high -> returns to WAIT_LOCK; release is 10 edges after the second rise; retry_cnt=0.
REQ-035 Timeout: locked held low -> two pll_rst pulses of 4 cycles; retry_cnt reaches 2; fault=1 after the second 32-cycle timeout; sys_rst stays 1.
REQ-036 Loss in RUN: drop locked while ready=1 -> sys_rst=1 and pll_rst=1 within 3 edges; loss_cnt=1; the full sequence repeats.
REQ-037 Recovery and reset: relock_req while in FAULT -> fault=0 and retry_cnt=0, PLLRST restarts. Assert rst mid-STABLE -> all outputs return to reset values on the next edge.
REQ-038 Saturation: 256 lock losses -> loss_cnt holds at 255.
